// File: rtl/dmem_pkg.sv
// dmem_pkg: access size encodings and controller state type
package dmem_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word memory with per-byte write enables and registered read
module dmem_array #(
  parameter int DATA_W = 64,
  parameter int DEPTH = 4096
) (
  input  logic                      clk,
  input  logic                      en,
  input  logic [DATA_W/8-1:0]       be,
  input  logic [$clog2(DEPTH)-1:0]  addr,
  input  logic [DATA_W-1:0]         wdata,
  output logic [DATA_W-1:0]         rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < DATA_W / 8; i++)
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-outstanding load/store controller over a byte-enabled word memory
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          DATA_W  = 64,
  parameter int          DEPTH   = 4096,
  parameter logic [63:0] BASE    = 64'h0,
  parameter int          LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [63:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int AW = $clog2(DEPTH);
  localparam logic [63:0] SPAN = 64'(DEPTH) * 64'(NB);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  state_t state, state_n;
  logic [3:0] cnt;
  logic accept, err, we_q, err_q, uns_q;
  logic [1:0] size_q;
  logic [64:0] off;
  logic [LB-1:0] lane, lane_q;
  logic [NB-1:0] be;
  logic [DATA_W-1:0] rdata, sh, mask, top, ld;
  logic [DATA_W:0] lim;
  assign accept = req_valid && req_ready;
  // borrow out of the subtraction flags addresses below BASE
  assign off = {1'b0, req_addr} - {1'b0, BASE};
  assign lane = req_addr[LB-1:0];
  assign err = off[64] || off[63:0] >= SPAN
            || (req_addr[2:0] & ((3'd1 << req_size) - 3'd1)) != 3'd0
            || (DATA_W == 32 && req_size == SZ_D);
  assign be = (accept && req_we && !err)
            ? NB'((16'd1 << (5'd1 << req_size)) - 16'd1) << lane : '0;
  dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .en    (accept),
    .be    (be),
    .addr  (off[LB +: AW]),
    .wdata (req_wdata << {lane, 3'b000}),
    .rdata (rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= accept ? CNT_INIT : state == WAIT ? cnt - 4'd1 : cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q <= req_we;
      err_q <= err;
      uns_q <= req_unsigned;
      size_q <= req_size;
      lane_q <= lane;
    end
  end
  always_comb begin
    state_n = state == IDLE ? (accept ? (LATENCY > 1 ? WAIT : RESP) : IDLE)
            : state == WAIT ? (cnt == 4'd1 ? RESP : WAIT)
            : state == RESP ? (rsp_ready ? IDLE : RESP)
            : IDLE;
  end
  // lim = 1 << access bit width; mask covers the loaded bytes, top marks the sign bit
  assign sh = rdata >> {lane_q, 3'b000};
  assign lim = (DATA_W+1)'(1) << (8'd8 << size_q);
  assign mask = DATA_W'(lim - (DATA_W+1)'(1));
  assign top = mask & ~(mask >> 1);
  assign ld = (sh & mask) | ((!(uns_q && size_q != SZ_D) && |(sh & top)) ? ~mask : '0);
  always_comb begin
    req_ready = state == IDLE && !rst;
    rsp_valid = state == RESP;
    rsp_err = rsp_valid && err_q;
    rsp_rdata = (rsp_valid && !err_q && !we_q) ? ld : '0;
  end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DATA_W, 64, data word width in bits (power of two, >= 32).
REQ-002 Parameter DEPTH, 4096, number of DATA_W-bit words (power of two).
REQ-003 Parameter BASE, 64'h0, byte address of word 0; window is [BASE, BASE+DEPTH*DATA_W/8).
REQ-004 Parameter LATENCY, 1, cycles from request acceptance to rsp_valid (1..8).
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  controller can accept a request.
REQ-009 req_we  in  1  1 = store, 0 = load.
REQ-010 req_addr  in  64  byte address.
REQ-011 req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
REQ-012 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-013 req_wdata  in  DATA_W  store data, right-aligned.
REQ-014 rsp_valid  out  1  response present.
REQ-015 rsp_ready  in  1  consumer accepts response.
REQ-016 rsp_rdata  out  DATA_W  load result, extended to DATA_W; 0 for stores and errors.
REQ-017 rsp_err  out  1  access out of window or misaligned.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-019 A request SHALL be accepted on a rising edge with req_valid && req_ready; IDLE -> WAIT (LATENCY > 1) or IDLE -> RESP (LATENCY = 1).
REQ-020 WAIT SHALL decrement a counter loaded with LATENCY-1 on acceptance and move to RESP on the edge it reaches 1, so rsp_valid first rises exactly LATENCY cycles after the acceptance edge.
REQ-021 In RESP rsp_valid = 1; rsp_rdata and rsp_err SHALL hold stable until the edge with rsp_ready = 1, then the FSM SHALL return to IDLE.
REQ-022 No new request SHALL be accepted on the edge the response retires; the next acceptance is one cycle later at the earliest.
REQ-023 Error SHALL be flagged when req_addr is outside the window or req_addr is not a multiple of 2^req_size.
REQ-024 req_size = 3 with DATA_W = 32 SHALL be treated as an error.
REQ-025 An errored store SHALL not modify memory; an errored load SHALL return rsp_rdata = 0; both SHALL still produce exactly one response.
REQ-026 Word index SHALL be (req_addr - BASE) >> log2(DATA_W/8); byte lane is the low log2(DATA_W/8) address bits.
REQ-027 A valid store SHALL write only the 2^req_size byte lanes starting at the lane offset, taking bytes from the low end of req_wdata, on the acceptance edge.
REQ-028 A valid load SHALL extract 2^req_size bytes from the lane offset and extend per req_unsigned; a double load ignores req_unsigned.
REQ-029 A load issued after a store to the same word SHALL return the stored value (write committed before the load is accepted).
REQ-030 Memory contents SHALL power up to zero and SHALL not be cleared by rst.

Reset
REQ-031 rst SHALL force the state to IDLE, counter to 0, rsp_valid = 0, rsp_err = 0 and rsp_rdata = 0 on the next edge; req_ready = 1 in the cycle after reset.
REQ-032 rst during WAIT or RESP SHALL abort the pending response (never delivered); a store committed at acceptance SHALL remain written.
REQ-033 A request presented while rst = 1 SHALL not be accepted.

Structure
REQ-034 Package dmem_pkg SHALL hold the size encodings (SZ_B, SZ_H, SZ_W, SZ_D) and the FSM state enum.
REQ-035 Storage SHALL be a sub-module dmem_array: single-port, DEPTH x DATA_W, per-byte write enable, registered read; dmem_ctrl holds FSM, decode, lane shifting and extension.

Verification
REQ-036 Store double 64'h1122334455667788 to 0x10, load double 0x10 -> rsp_rdata = 64'h1122334455667788, rsp_err = 0, rsp_valid LATENCY cycles after acceptance.
REQ-037 Store byte 8'h80 to 0x23, load signed byte 0x23 -> 64'hFFFFFFFFFFFFFF80; unsigned -> 64'h80; load double 0x20 -> 64'h0000000080000000 after zeroed memory.
REQ-038 Load half at 0x21 -> rsp_err = 1, rsp_rdata = 0; store word at BASE+DEPTH*8 -> rsp_err = 1, memory unchanged (readback at 0x0 unaffected).
REQ-039 LATENCY = 4, rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable all 5 cycles, req_ready = 0 until one cycle after retirement.
REQ-040 Assert rst one cycle after accepting a store of 32'hDEADBEEF to 0x8 -> no response delivered, req_ready = 1 after reset, subsequent unsigned word load of 0x8 returns 64'hDEADBEEF.
